// File: rtl/full_adder_pkg.sv
// Shared arithmetic helpers for the full_adder ripple chain.
package full_adder_pkg;

  // Majority-of-three: the carry-out of a single full-adder bit.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder leaf cell: sum and carry-out of a, b and carry-in.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with an optional one-cycle output register.
module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          OUT_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] sum_c;

  assign k[0] = c;

  // Ripple chain: carry of bit i feeds bit i+1.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (k[i]),
      .s    (sum_c[i]),
      .cout (k[i+1])
    );
  end

  if (OUT_REG) begin : g_reg
    // Capture on valid, hold data otherwise; valid tracks in_valid one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum       <= '0;
        carry     <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sum   <= sum_c;
          carry <= k[WIDTH];
        end
      end
    end
  end else begin : g_comb
    // Clock and reset play no part in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum       = sum_c;
    assign carry     = k[WIDTH];
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder.sv
// Randomised self-checking bench for full_adder across combinational and registered builds.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // WIDTH=1 combinational
  logic       a1, b1, c1, v1, s1, k1, ov1;
  // WIDTH=8 combinational
  logic [7:0] a8c, b8c, s8c;
  logic       c8c, v8c, k8c, ov8c;
  // WIDTH=8 registered
  logic [7:0] a8r, b8r, s8r;
  logic       c8r, v8r, k8r, ov8r;
  // WIDTH=4 registered
  logic [3:0] a4r, b4r, s4r;
  logic       c4r, v4r, k4r, ov4r;

  full_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_w1c (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .in_valid(v1),
    .sum(s1), .carry(k1), .out_valid(ov1));

  full_adder #(.WIDTH(8), .OUT_REG(1'b0)) u_w8c (
    .clk(clk), .rst_n(rst_n), .a(a8c), .b(b8c), .c(c8c), .in_valid(v8c),
    .sum(s8c), .carry(k8c), .out_valid(ov8c));

  full_adder #(.WIDTH(8), .OUT_REG(1'b1)) u_w8r (
    .clk(clk), .rst_n(rst_n), .a(a8r), .b(b8r), .c(c8r), .in_valid(v8r),
    .sum(s8r), .carry(k8r), .out_valid(ov8r));

  full_adder #(.WIDTH(4), .OUT_REG(1'b1)) u_w4r (
    .clk(clk), .rst_n(rst_n), .a(a4r), .b(b4r), .c(c4r), .in_valid(v4r),
    .sum(s4r), .carry(k4r), .out_valid(ov4r));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer sum; low WIDTH bits are sum, bit WIDTH is carry.
  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci);
    return 65'(x) + 65'(y) + 65'(ci);
  endfunction

  logic [64:0] t;
  logic [7:0]  hold_s;
  logic        hold_k;

  task automatic comb8(input logic [7:0] x, input logic [7:0] y, input logic ci, input string tag);
    a8c = x; b8c = y; c8c = ci;
    #1;
    t = ref_add(64'(x), 64'(y), ci);
    check({tag, "_sum"}, 64'(s8c), 64'(t[7:0]));
    check({tag, "_carry"}, 64'(k8c), 64'(t[8]));
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 0; b1 = 0; c1 = 0; v1 = 1'b1;
    a8c = '0; b8c = '0; c8c = 0; v8c = 1'b1;
    a8r = '0; b8r = '0; c8r = 0; v8r = 1'b0;
    a4r = '0; b4r = '0; c4r = 0; v4r = 1'b0;

    // Reset state of the registered builds
    @(negedge clk);
    check("rst_w8_sum", 64'(s8r), 64'h0);
    check("rst_w8_carry", 64'(k8r), 64'h0);
    check("rst_w8_valid", 64'(ov8r), 64'h0);
    check("rst_w4_valid", 64'(ov4r), 64'h0);

    // WIDTH=1 full truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      {a1, b1, c1} = abc;
      #10;
      t = ref_add(64'(abc[2]), 64'(abc[1]), abc[0]);
      check($sformatf("w1_sum_%0d", i), 64'(s1), 64'(t[0]));
      check($sformatf("w1_carry_%0d", i), 64'(k1), 64'(t[1]));
    end
    check("w1_valid", 64'(ov1), 64'h1);
    v1 = 1'b0; #1;
    check("w1_valid_low", 64'(ov1), 64'h0);

    // WIDTH=8 combinational boundaries and random vectors
    comb8(8'hFF, 8'h00, 1'b1, "w8c_ff00");
    comb8(8'h5A, 8'hA5, 1'b0, "w8c_5aa5");
    comb8(8'hFF, 8'hFF, 1'b1, "w8c_allones");
    comb8(8'h00, 8'h00, 1'b0, "w8c_zero");
    for (int i = 0; i < 20; i++)
      comb8(8'($urandom), 8'($urandom), 1'($urandom), "w8c_rand");

    // WIDTH=8 registered: capture, then hold with in_valid low
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); a8r = 8'h80; b8r = 8'h80; c8r = 1'b1; v8r = 1'b1;
    @(posedge clk); #1;
    check("w8r_sum", 64'(s8r), 64'h01);
    check("w8r_carry", 64'(k8r), 64'h1);
    check("w8r_valid", 64'(ov8r), 64'h1);
    @(negedge clk); v8r = 1'b0; a8r = 8'h13; b8r = 8'h07; c8r = 1'b0;
    @(posedge clk); #1;
    check("w8r_hold_valid", 64'(ov8r), 64'h0);
    check("w8r_hold_sum", 64'(s8r), 64'h01);
    check("w8r_hold_carry", 64'(k8r), 64'h1);

    // Asynchronous reset between edges while out_valid is high
    @(negedge clk); a8r = 8'hFF; b8r = 8'hFF; c8r = 1'b1; v8r = 1'b1;
    @(posedge clk); #1;
    check("w8r_ones_sum", 64'(s8r), 64'hFF);
    check("w8r_ones_carry", 64'(k8r), 64'h1);
    #1; a8c = 8'h10; b8c = 8'h20; c8c = 1'b1;
    rst_n = 1'b0; #1;
    check("arst_sum", 64'(s8r), 64'h0);
    check("arst_carry", 64'(k8r), 64'h0);
    check("arst_valid", 64'(ov8r), 64'h0);
    check("arst_comb_unaffected", 64'(s8c), 64'h31);
    @(negedge clk); a8r = 8'h12; b8r = 8'h34; c8r = 1'b0; v8r = 1'b1;
    @(posedge clk); #1;
    check("arst_held_sum", 64'(s8r), 64'h0);
    check("arst_held_valid", 64'(ov8r), 64'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rel_no_edge_valid", 64'(ov8r), 64'h0);
    @(posedge clk); #1;
    check("rel_first_sum", 64'(s8r), 64'h46);
    check("rel_first_carry", 64'(k8r), 64'h0);
    check("rel_first_valid", 64'(ov8r), 64'h1);

    // WIDTH=4 registered streaming, one result per cycle
    for (int i = 0; i < 200; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      @(negedge clk);
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      a4r = ra; b4r = rb; c4r = rc; v4r = 1'b1;
      @(posedge clk); #1;
      t = ref_add(64'(ra), 64'(rb), rc);
      check($sformatf("w4r_sum_%0d", i), 64'(s4r), 64'(t[3:0]));
      check($sformatf("w4r_carry_%0d", i), 64'(k4r), 64'(t[4]));
      check($sformatf("w4r_valid_%0d", i), 64'(ov4r), 64'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
